// File: rtl/fetch_unit.sv
// fetch_unit: instruction-fetch stage. Holds the PC, fetches words over an
// enable/MOC handshake and presents one instruction at a time to decode.
// Optional feature macro: FETCH_TIMEOUT_EN (fetch timeout with fetch_err pulse).
module fetch_unit #(
   parameter int unsigned          ADDR_W    = 32,
   parameter int unsigned          INSTR_W   = 32,
   parameter logic [ADDR_W-1:0]    RESET_VEC = '0,
   parameter int unsigned          MAX_WAIT  = 15
) (
   input  logic               Clk,
   input  logic               Reset_n,
   input  logic               stall,
   input  logic               redirect,
   input  logic [ADDR_W-1:0]  redirect_target,
   output logic               mem_en,
   output logic [ADDR_W-1:0]  mem_addr,
   input  logic [INSTR_W-1:0] mem_rdata,
   input  logic               MOC,
   output logic [INSTR_W-1:0] Instruction,
   output logic               instr_valid,
   output logic [ADDR_W-1:0]  PC,
   output logic               fetch_err
);

   typedef enum logic [1:0] {IDLE, FETCH, VALID} state_t;

   state_t            state;
   logic [ADDR_W-1:0] target_aligned;
   logic [ADDR_W-1:0] pc_inc;

   // Elaboration-time parameter sanity checks
   if (INSTR_W != 32) begin : g_bad_instr_w
      $error("fetch_unit: INSTR_W must be 32");
   end
   if (ADDR_W < 3) begin : g_bad_addr_w
      $error("fetch_unit: ADDR_W must be at least 3");
   end
   if (RESET_VEC[1:0] != 2'b00) begin : g_bad_reset_vec
      $error("fetch_unit: RESET_VEC must be word aligned");
   end
   if (MAX_WAIT < 1) begin : g_bad_max_wait
      $error("fetch_unit: MAX_WAIT must be at least 1");
   end

   // Word-aligned redirect target and sequential next PC (wraps silently)
   always_comb begin
      target_aligned = redirect_target & ~ADDR_W'(3);
      pc_inc         = PC + ADDR_W'(4);
   end

`ifdef FETCH_TIMEOUT_EN
   localparam int unsigned CNT_W = (MAX_WAIT < 1) ? 1 : $clog2(MAX_WAIT + 1);
   logic [CNT_W-1:0] wait_cnt;
`else
   assign fetch_err = 1'b0;
`endif

   // Fetch FSM with registered handshake and decode-side outputs
   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         state       <= IDLE;
         PC          <= RESET_VEC;
         Instruction <= '0;
         instr_valid <= 1'b0;
         mem_en      <= 1'b0;
         mem_addr    <= RESET_VEC;
`ifdef FETCH_TIMEOUT_EN
         fetch_err   <= 1'b0;
         wait_cnt    <= '0;
`endif
      end else begin
`ifdef FETCH_TIMEOUT_EN
         fetch_err <= 1'b0;
`endif
         case (state)
            IDLE: begin
               state    <= FETCH;
               mem_en   <= 1'b1;
               mem_addr <= PC;
            end
            FETCH: begin
               if (redirect) begin
                  // Redirect beats a same-cycle MOC; its data is dropped
                  state    <= IDLE;
                  PC       <= target_aligned;
                  mem_addr <= target_aligned;
                  mem_en   <= 1'b0;
`ifdef FETCH_TIMEOUT_EN
                  wait_cnt <= '0;
`endif
               end else if (MOC) begin
                  state       <= VALID;
                  Instruction <= mem_rdata;
                  instr_valid <= 1'b1;
                  mem_en      <= 1'b0;
`ifdef FETCH_TIMEOUT_EN
                  wait_cnt    <= '0;
`endif
               end
`ifdef FETCH_TIMEOUT_EN
               else if (wait_cnt == CNT_W'(MAX_WAIT - 1)) begin
                  // Give up and re-request the same PC after an IDLE bubble
                  state     <= IDLE;
                  mem_en    <= 1'b0;
                  fetch_err <= 1'b1;
                  wait_cnt  <= '0;
               end else begin
                  wait_cnt <= wait_cnt + CNT_W'(1);
               end
`endif
            end
            VALID: begin
               if (redirect) begin
                  state       <= FETCH;
                  PC          <= target_aligned;
                  mem_addr    <= target_aligned;
                  mem_en      <= 1'b1;
                  instr_valid <= 1'b0;
               end else if (!stall) begin
                  state       <= FETCH;
                  PC          <= pc_inc;
                  mem_addr    <= pc_inc;
                  mem_en      <= 1'b1;
                  instr_valid <= 1'b0;
               end
            end
            default: begin
               state       <= IDLE;
               mem_en      <= 1'b0;
               instr_valid <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: table-driven directed bench for fetch_unit plus hand-written
// sequences for timeout (FETCH_TIMEOUT_EN) and asynchronous reset mid-fetch.
module tb_fetch_unit;

   logic        Clk = 1'b0;
   logic        Reset_n = 1'b0;
   logic        stall = 1'b0;
   logic        redirect = 1'b0;
   logic [31:0] redirect_target = '0;
   logic        mem_en;
   logic [31:0] mem_addr;
   logic [31:0] mem_rdata = '0;
   logic        MOC = 1'b0;
   logic [31:0] Instruction;
   logic        instr_valid;
   logic [31:0] PC;
   logic        fetch_err;

   int checks = 0;
   int failures = 0;

   fetch_unit #(
      .ADDR_W(32), .INSTR_W(32), .RESET_VEC(32'h0000_0100), .MAX_WAIT(4)
   ) dut (
      .Clk(Clk), .Reset_n(Reset_n), .stall(stall), .redirect(redirect),
      .redirect_target(redirect_target), .mem_en(mem_en), .mem_addr(mem_addr),
      .mem_rdata(mem_rdata), .MOC(MOC), .Instruction(Instruction),
      .instr_valid(instr_valid), .PC(PC), .fetch_err(fetch_err)
   );

   always #5 Clk = ~Clk;

   typedef struct {
      logic        stall;
      logic        redirect;
      logic [31:0] target;
      logic        moc;
      logic [31:0] rdata;
      logic        exp_en;
      logic [31:0] exp_addr;
      logic        exp_valid;
      logic [31:0] exp_instr;
      logic [31:0] exp_pc;
   } vec_t;

   vec_t vecs[19];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic check_all(input string tag, input logic en, input logic [31:0] addr,
                            input logic valid, input logic [31:0] instr, input logic [31:0] pc,
                            input logic err);
      check({tag, "_mem_en"}, 32'(mem_en), 32'(en));
      check({tag, "_mem_addr"}, mem_addr, addr);
      check({tag, "_valid"}, 32'(instr_valid), 32'(valid));
      check({tag, "_instr"}, Instruction, instr);
      check({tag, "_pc"}, PC, pc);
      check({tag, "_fetch_err"}, 32'(fetch_err), 32'(err));
   endtask

   initial begin
      // stall redir target moc rdata | en addr valid instr pc
      vecs[0]  = '{0, 0, 32'h0, 0, 32'h0,          1, 32'h100, 0, 32'h0, 32'h100};
      vecs[1]  = '{0, 0, 32'h0, 0, 32'h0,          1, 32'h100, 0, 32'h0, 32'h100};
      vecs[2]  = '{0, 0, 32'h0, 0, 32'h0,          1, 32'h100, 0, 32'h0, 32'h100};
      vecs[3]  = '{0, 0, 32'h0, 1, 32'h2401_0000,  0, 32'h100, 1, 32'h2401_0000, 32'h100};
      vecs[4]  = '{1, 0, 32'h0, 1, 32'hFFFF_FFFF,  0, 32'h100, 1, 32'h2401_0000, 32'h100};
      vecs[5]  = '{1, 0, 32'h0, 0, 32'h0,          0, 32'h100, 1, 32'h2401_0000, 32'h100};
      vecs[6]  = '{1, 0, 32'h0, 1, 32'hFFFF_FFFF,  0, 32'h100, 1, 32'h2401_0000, 32'h100};
      vecs[7]  = '{1, 0, 32'h0, 0, 32'h0,          0, 32'h100, 1, 32'h2401_0000, 32'h100};
      vecs[8]  = '{1, 0, 32'h0, 1, 32'hFFFF_FFFF,  0, 32'h100, 1, 32'h2401_0000, 32'h100};
      vecs[9]  = '{0, 0, 32'h0, 0, 32'h0,          1, 32'h104, 0, 32'h2401_0000, 32'h104};
      vecs[10] = '{0, 1, 32'h13, 1, 32'h1111_1111, 0, 32'h10,  0, 32'h2401_0000, 32'h10};
      vecs[11] = '{0, 0, 32'h0, 0, 32'h0,          1, 32'h10,  0, 32'h2401_0000, 32'h10};
      vecs[12] = '{0, 0, 32'h0, 1, 32'hAABB_CCDD,  0, 32'h10,  1, 32'hAABB_CCDD, 32'h10};
      vecs[13] = '{1, 1, 32'hFFFF_FFFE, 0, 32'h0,  1, 32'hFFFF_FFFC, 0, 32'hAABB_CCDD, 32'hFFFF_FFFC};
      vecs[14] = '{0, 0, 32'h0, 1, 32'h0BAD_F00D,  0, 32'hFFFF_FFFC, 1, 32'h0BAD_F00D, 32'hFFFF_FFFC};
      vecs[15] = '{0, 0, 32'h0, 0, 32'h0,          1, 32'h0,   0, 32'h0BAD_F00D, 32'h0};
      vecs[16] = '{0, 0, 32'h0, 0, 32'h0,          1, 32'h0,   0, 32'h0BAD_F00D, 32'h0};
      vecs[17] = '{0, 0, 32'h0, 1, 32'h1234_5678,  0, 32'h0,   1, 32'h1234_5678, 32'h0};
      vecs[18] = '{0, 0, 32'h0, 0, 32'h0,          1, 32'h4,   0, 32'h1234_5678, 32'h4};

      // Reset state while held in reset
      #12;
      check_all("reset", 1'b0, 32'h100, 1'b0, 32'h0, 32'h100, 1'b0);

      // Release reset away from the clock edge
      @(negedge Clk);
      Reset_n = 1'b1;

      for (int i = 0; i < 19; i++) begin
         stall           = vecs[i].stall;
         redirect        = vecs[i].redirect;
         redirect_target = vecs[i].target;
         MOC             = vecs[i].moc;
         mem_rdata       = vecs[i].rdata;
         @(posedge Clk);
         #1;
         check_all($sformatf("v%0d", i), vecs[i].exp_en, vecs[i].exp_addr,
                   vecs[i].exp_valid, vecs[i].exp_instr, vecs[i].exp_pc, 1'b0);
      end

      stall = 1'b0; redirect = 1'b0; MOC = 1'b0; mem_rdata = '0;
`ifdef FETCH_TIMEOUT_EN
      // MAX_WAIT=4: three waiting FETCH cycles, timeout on the fourth
      for (int i = 0; i < 3; i++) begin
         @(posedge Clk);
         #1;
         check_all($sformatf("tmo_wait%0d", i), 1'b1, 32'h4, 1'b0, 32'h1234_5678, 32'h4, 1'b0);
      end
      @(posedge Clk);
      #1;
      check_all("tmo_pulse", 1'b0, 32'h4, 1'b0, 32'h1234_5678, 32'h4, 1'b1);
      @(posedge Clk);
      #1;
      check_all("tmo_rereq", 1'b1, 32'h4, 1'b0, 32'h1234_5678, 32'h4, 1'b0);
`else
      // Without timeout the fetch waits indefinitely with no error
      for (int i = 0; i < 8; i++) begin
         @(posedge Clk);
         #1;
         check_all($sformatf("wait%0d", i), 1'b1, 32'h4, 1'b0, 32'h1234_5678, 32'h4, 1'b0);
      end
`endif

      // Asynchronous reset mid-FETCH clears outputs without a clock edge
      #3;
      Reset_n = 1'b0;
      #1;
      check_all("async_rst", 1'b0, 32'h100, 1'b0, 32'h0, 32'h100, 1'b0);
      MOC = 1'b1;
      mem_rdata = 32'hDEAD_BEEF;
      @(posedge Clk);
      #1;
      check_all("in_rst", 1'b0, 32'h100, 1'b0, 32'h0, 32'h100, 1'b0);
      #4;
      Reset_n = 1'b1;
      // Late MOC ignored in IDLE; capture happens on the next FETCH cycle
      @(posedge Clk);
      #1;
      check_all("late_moc", 1'b1, 32'h100, 1'b0, 32'h0, 32'h100, 1'b0);
      @(posedge Clk);
      #1;
      check_all("post_rst_fetch", 1'b0, 32'h100, 1'b1, 32'hDEAD_BEEF, 32'h100, 1'b0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
